// File: rtl/pc_seq_pkg.sv
// Shared constants and next-PC source encoding for the PC sequencer.
package pc_seq_pkg;

    localparam int unsigned DEF_ADDR_W    = 32;
    localparam int unsigned DEF_STEP      = 4;
    localparam int unsigned DEF_PC_LIMIT  = 248;
    localparam int unsigned DEF_RESET_VEC = 0;
    localparam int unsigned DEF_RAS_DEPTH = 4;

    typedef enum logic [1:0] {
        HOLD,
        REDIRECT,
        RETURN,
        SEQ
    } pc_src_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack with occupancy count and sticky overflow/underflow flags.
module pc_ras
    import pc_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DEPTH  = DEF_RAS_DEPTH
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [ADDR_W-1:0]        i_push_data,
    output logic [ADDR_W-1:0]        o_top_c,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    output logic                     o_underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              r_underflow;
    logic              w_full;
    logic              w_empty;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // Write pointer always advances on push, so a full stack overwrites its oldest entry.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (i_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_full) begin
                r_overflow <= 1'b1;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end else if (i_pop) begin
            if (w_empty) begin
                r_underflow <= 1'b1;
            end else begin
                r_wr_ptr <= r_wr_ptr - PTR_W'(1);
                r_count  <= r_count - CNT_W'(1);
            end
        end
    end

    // Entry storage carries no reset; contents are only consumed when the count is non-zero.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_top_c     = r_mem[r_wr_ptr - PTR_W'(1)];
    assign o_count     = r_count;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: stall/redirect/return/sequential selection with limit wrap and RAS.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned STEP      = DEF_STEP,
    parameter int unsigned PC_LIMIT  = DEF_PC_LIMIT,
    parameter int unsigned RESET_VEC = DEF_RESET_VEC,
    parameter int unsigned RAS_DEPTH = DEF_RAS_DEPTH
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         Stall,
    input  logic                         Redirect,
    input  logic [ADDR_W-1:0]            RedirectPC,
    input  logic                         Call,
    input  logic                         Return,
    output logic [ADDR_W-1:0]            PC,
    output logic [ADDR_W-1:0]            PCPlus,
    output logic [$clog2(RAS_DEPTH):0]   RasCount,
    output logic                         RasOverflow,
    output logic                         RasUnderflow
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_plus;
    logic [ADDR_W-1:0] w_ras_top;
    logic [ADDR_W-1:0] w_cand;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_ras_empty;
    logic              w_push;
    logic              w_pop;
    pc_src_e           w_src;

    assign w_pc_plus   = r_pc + ADDR_W'(STEP);
    assign w_ras_empty = (RasCount == '0);

    always_comb begin
        w_src = SEQ;
        if (Stall) begin
            w_src = HOLD;
        end else if (Redirect) begin
            w_src = REDIRECT;
        end else if (Return) begin
            w_src = RETURN;
        end
    end

    // A return on an empty stack falls through to the sequential address.
    always_comb begin
        w_cand = r_pc;
        case (w_src)
            HOLD:     w_cand = r_pc;
            REDIRECT: w_cand = RedirectPC;
            RETURN:   w_cand = w_ras_empty ? w_pc_plus : w_ras_top;
            SEQ:      w_cand = w_pc_plus;
            default:  w_cand = r_pc;
        endcase
    end

    always_comb begin
        w_next_pc = w_cand;
        if ((w_src != HOLD) && (w_cand > ADDR_W'(PC_LIMIT))) begin
            w_next_pc = ADDR_W'(RESET_VEC);
        end
    end

    assign w_push = (w_src == REDIRECT) && Call;
    assign w_pop  = (w_src == RETURN);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_pc <= ADDR_W'(RESET_VEC);
        end else begin
            r_pc <= w_next_pc;
        end
    end

    pc_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .i_clk       (Clock),
        .i_rst       (Reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_pc_plus),
        .o_top_c     (w_ras_top),
        .o_count     (RasCount),
        .o_overflow  (RasOverflow),
        .o_underflow (RasUnderflow)
    );

    assign PC     = r_pc;
    assign PCPlus = w_pc_plus;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer with default parameters.
module tb_pc_sequencer;

    logic        Clock      = 1'b0;
    logic        Reset      = 1'b0;
    logic        Stall      = 1'b0;
    logic        Redirect   = 1'b0;
    logic [31:0] RedirectPC = 32'h0;
    logic        Call       = 1'b0;
    logic        Return     = 1'b0;
    logic [31:0] PC;
    logic [31:0] PCPlus;
    logic [2:0]  RasCount;
    logic        RasOverflow;
    logic        RasUnderflow;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [2:0]  cnt;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    pc_sequencer dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Stall        (Stall),
        .Redirect     (Redirect),
        .RedirectPC   (RedirectPC),
        .Call         (Call),
        .Return       (Return),
        .PC           (PC),
        .PCPlus       (PCPlus),
        .RasCount     (RasCount),
        .RasOverflow  (RasOverflow),
        .RasUnderflow (RasUnderflow)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input exp_t e);
        chk({e.tag, ".pc"},     PC,                 e.pc);
        chk({e.tag, ".pcplus"}, PCPlus,             e.pc + 32'd4);
        chk({e.tag, ".cnt"},    32'(RasCount),      32'(e.cnt));
        chk({e.tag, ".ovf"},    32'(RasOverflow),   32'(e.ovf));
        chk({e.tag, ".unf"},    32'(RasUnderflow),  32'(e.unf));
    endtask

    // Drive at the falling edge, expect after the next rising edge.
    task automatic step(input string tag, input logic st, input logic rd, input logic [31:0] rpc,
                        input logic cl, input logic rt, input logic [31:0] epc,
                        input logic [2:0] ecnt, input logic eo, input logic eu);
        exp_t e;
        Stall      = st;
        Redirect   = rd;
        RedirectPC = rpc;
        Call       = cl;
        Return     = rt;
        sb.push_back('{tag, epc, ecnt, eo, eu});
        @(posedge Clock);
        #1;
        e = sb.pop_front();
        check_state(e);
        @(negedge Clock);
    endtask

    initial begin
        #1 Reset = 1'b1;
        #1 check_state('{"reset", 32'h0, 3'd0, 1'b0, 1'b0});
        @(negedge Clock);
        Reset = 1'b0;

        step("idle1", 0, 0, 32'h0, 0, 0, 32'h04, 3'd0, 0, 0);
        step("idle2", 0, 0, 32'h0, 0, 0, 32'h08, 3'd0, 0, 0);
        step("idle3", 0, 0, 32'h0, 0, 0, 32'h0C, 3'd0, 0, 0);
        step("idle4", 0, 0, 32'h0, 0, 0, 32'h10, 3'd0, 0, 0);

        step("call80", 0, 1, 32'h80, 1, 0, 32'h80, 3'd1, 0, 0);
        step("body1",  0, 0, 32'h0,  0, 0, 32'h84, 3'd1, 0, 0);
        step("body2",  0, 0, 32'h0,  0, 0, 32'h88, 3'd1, 0, 0);
        step("ret14",  0, 0, 32'h0,  0, 1, 32'h14, 3'd0, 0, 0);

        step("call1", 0, 1, 32'h40, 1, 0, 32'h40, 3'd1, 0, 0);
        step("call2", 0, 1, 32'h50, 1, 0, 32'h50, 3'd2, 0, 0);
        step("call3", 0, 1, 32'h60, 1, 0, 32'h60, 3'd3, 0, 0);
        step("call4", 0, 1, 32'h70, 1, 0, 32'h70, 3'd4, 0, 0);
        step("call5", 0, 1, 32'h90, 1, 0, 32'h90, 3'd4, 1, 0);
        step("ret1",  0, 0, 32'h0,  0, 1, 32'h74, 3'd3, 1, 0);
        step("ret2",  0, 0, 32'h0,  0, 1, 32'h64, 3'd2, 1, 0);
        step("ret3",  0, 0, 32'h0,  0, 1, 32'h54, 3'd1, 1, 0);
        step("ret4",  0, 0, 32'h0,  0, 1, 32'h44, 3'd0, 1, 0);
        step("ret5",  0, 0, 32'h0,  0, 1, 32'h48, 3'd0, 1, 1);

        step("callA",     0, 1, 32'hA0, 1, 0, 32'hA0, 3'd1, 1, 1);
        step("callB",     0, 1, 32'hB0, 1, 0, 32'hB0, 3'd2, 1, 1);
        step("redir_ret", 0, 1, 32'hC0, 0, 1, 32'hC0, 3'd2, 1, 1);
        step("retA4",     0, 0, 32'h0,  0, 1, 32'hA4, 3'd1, 1, 1);
        step("call_only", 0, 0, 32'h0,  1, 0, 32'hA8, 3'd1, 1, 1);

        step("stall1", 1, 1, 32'hDEAD0, 1, 1, 32'hA8, 3'd1, 1, 1);
        step("stall2", 1, 1, 32'hDEAD0, 1, 1, 32'hA8, 3'd1, 1, 1);
        Reset = 1'b1;
        #2 check_state('{"stall_rst", 32'h0, 3'd0, 1'b0, 1'b0});
        Reset = 1'b0;
        step("stall_post", 1, 1, 32'hDEAD0, 1, 1, 32'h0, 3'd0, 0, 0);
        step("first_run",  0, 0, 32'h0,     0, 0, 32'h4, 3'd0, 0, 0);

        step("lim_set",   0, 1, 32'hF8,  0, 0, 32'hF8, 3'd0, 0, 0);
        step("lim_wrap",  0, 0, 32'h0,   0, 0, 32'h0,  3'd0, 0, 0);
        step("redir_big", 0, 1, 32'h100, 0, 0, 32'h0,  3'd0, 0, 0);
        step("call_big",  0, 1, 32'h100, 1, 0, 32'h0,  3'd1, 0, 0);
        step("ret_big",   0, 0, 32'h0,   0, 1, 32'h4,  3'd0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_W, default 32, PC and address width in bits.
REQ-002 Parameter STEP, default 4, sequential PC increment.
REQ-003 Parameter PC_LIMIT, default 248, highest legal PC; any larger next-PC is replaced by RESET_VEC.
REQ-004 Parameter RESET_VEC, default 0, PC value after reset and after a limit wrap.
REQ-005 Parameter RAS_DEPTH, default 4, return-address-stack entries; power of two, at least 2.
REQ-006 Port Clock, input, 1, single clock; all state updates on the rising edge.
REQ-007 Port Reset, input, 1, asynchronous, active-high reset.
REQ-008 Port Stall, input, 1, holds all state for the cycle.
REQ-009 Port Redirect, input, 1, load RedirectPC as the next PC.
REQ-010 Port RedirectPC, input, ADDR_W, jump, branch or call target.
REQ-011 Port Call, input, 1, qualifies Redirect as a call and pushes the return address.
REQ-012 Port Return, input, 1, next PC is popped from the RAS.
REQ-013 Port PC, output, ADDR_W, registered current PC.
REQ-014 Port PCPlus, output, ADDR_W, combinational PC+STEP.
REQ-015 Port RasCount, output, clog2(RAS_DEPTH)+1, registered occupied-entry count.
REQ-016 Port RasOverflow, output, 1, registered sticky flag set when a push hits a full stack.
REQ-017 Port RasUnderflow, output, 1, registered sticky flag set when a pop hits an empty stack.

Function
REQ-018 The next-PC candidate SHALL be selected by this priority:
- Stall=1: hold PC, RAS and flags.
- Redirect=1: RedirectPC.
- Return=1: RAS top.
- Otherwise: PC+STEP.
REQ-019 Redirect=1 with Call=1 (Stall=0) SHALL push PC+STEP and load RedirectPC in the same edge.
REQ-020 Call=1 with Redirect=0 SHALL be ignored: no push, no flag change.
REQ-021 Redirect=1 with Return=1 SHALL let Redirect win: no pop, RasCount unchanged.
REQ-022 Return with RasCount=0 SHALL load PC+STEP, leave RasCount at 0, and set RasUnderflow.
REQ-023 Push with RasCount=RAS_DEPTH SHALL overwrite the oldest entry (circular), keep RasCount at RAS_DEPTH, and set RasOverflow.
REQ-024 A candidate greater than PC_LIMIT (unsigned) SHALL be replaced by RESET_VEC; RAS push and pop effects of that cycle still apply.
REQ-025 All PC arithmetic SHALL be unsigned modulo 2^ADDR_W; PC+STEP overflow wraps before the limit check.
REQ-026 PC SHALL update with one-cycle latency: a control input sampled at edge N is visible on PC after edge N.
REQ-027 RasOverflow and RasUnderflow SHALL clear only on Reset.

Reset
REQ-028 Reset asserted SHALL immediately force PC=RESET_VEC, RasCount=0, RasOverflow=0, RasUnderflow=0, independent of Clock.
REQ-029 Reset SHALL override Stall, Redirect, Call and Return, including mid-stall.
REQ-030 RAS entry contents need not be reset; they SHALL be unobservable while RasCount=0.
REQ-031 The first rising edge after Reset deasserts SHALL apply normal next-PC selection.

Structure
REQ-032 Shared package pc_seq_pkg SHALL hold the default parameter constants and a next-PC-source enumeration: HOLD, REDIRECT, RETURN, SEQ.
REQ-033 The RAS (storage, top pointer, count, overflow/underflow detection) SHALL be a sub-module named pc_ras.
REQ-034 The next-PC mux and limit check SHALL be in pc_sequencer; no latches; one asynchronous-reset clocked process per register group.

Verification
REQ-035 Reset, then 3 idle edges -> PC steps 0, 4, 8, 12; RasCount=0.
REQ-036 At PC=0x10, Redirect=1, Call=1, RedirectPC=0x80; 2 idle edges; Return=1 -> PC sequence 0x80, 0x84, 0x88, 0x14; RasCount goes 1 then 0.
REQ-037 Five calls with RAS_DEPTH=4, then five returns -> RasOverflow=1 after the fifth call; the first four returns yield the four newest return addresses; the fifth return yields PC+4 and sets RasUnderflow.
REQ-038 PC=248, idle edge -> PC=0; Redirect with RedirectPC=0x100 -> PC=0.
REQ-039 Stall=1 with Redirect, Call and Return all asserted -> PC, RasCount and flags unchanged; Reset pulsed between edges during the stall -> PC=0 immediately.
REQ-040 Redirect=1 and Return=1 with RasCount=2 -> PC=RedirectPC; RasCount stays 2.
